led_piso_tx: RTL and testbench
==============================

// Module: led_piso_tx
// PURPOSE
//  Parallel-in/serial-out LED shift transmitter: the send side of the board's SIPO LED shift chain.
//  Accepts a WIDTH-bit word, then shifts it out one bit per DIV clocks, LSB- or MSB-first per lr.
//  Contains its own bit-rate prescaler (DIV=50_000_000 gives 1 bit/s at 50 MHz).
//  Drives an external SIPO chain or a single LED; pending[] mirrors the unsent bits onto the LED bank.
// PARAMETERS
//  WIDTH  8           word length in bits (>=2)
//  DIV    50_000_000  clocks per serial bit (>=1); counter width $clog2(DIV) (min 1)
// PORTS
//  clk      in   1      system clock; all logic on rising edge
//  rst_n    in   1      synchronous reset, active-low
//  lr       in   1      direction: 1 = LSB first (shift right), 0 = MSB first (shift left); latched at load
//  load     in   1      request to start a frame with d_in; accepted only in IDLE
//  d_in     in   WIDTH  parallel word to transmit
//  s_out    out  1      serial data bit
//  s_valid  out  1      high while s_out carries a frame bit (state SHIFT)
//  busy     out  1      high in SHIFT (load is ignored whenever busy or done)
//  done     out  1      one-cycle pulse after the last bit period ends
//  pending  out  WIDTH  current shift register contents (unsent bits; vacated positions = 0)
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE; shreg, bit_cnt, div_cnt, dir=0; s_out, s_valid, busy, done=0.
//   Reset wins over every other input. Mid-frame reset aborts the frame with no done pulse.
//  FSM states: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE: s_out=0, s_valid=0, busy=0. At an edge with load=1: shreg<=d_in, dir<=lr, bit_cnt<=0,
//   div_cnt<=0, state<=SHIFT. If load=0, stay in IDLE.
//  SHIFT: s_out = dir ? shreg[0] : shreg[WIDTH-1] (combinational from regs); s_valid=1; busy=1.
//   div_cnt increments each clock; tick = (div_cnt==DIV-1); on tick div_cnt<=0.
//   On tick and bit_cnt==WIDTH-1: state<=DONE (shreg unchanged).
//   On tick otherwise: bit_cnt++; shreg shifts toward the output end (dir=1: >>1, MSB<=0;
//    dir=0: <<1, LSB<=0).
//  DONE: exactly one cycle; done=1, busy=0, s_valid=0, s_out=0; next state IDLE unconditionally.
//  Timing: if load is accepted at edge N, bit k (k=0..WIDTH-1) is on s_out for cycles N+1+k*DIV through
//   N+(k+1)*DIV. done is high in cycle N+WIDTH*DIV+1. With load held high, the next frame is accepted at
//   the IDLE edge, so consecutive frames are separated by 2 cycles (DONE, IDLE).
//  load, d_in and lr are ignored outside IDLE. A lr change mid-frame has no effect on bit order.
//  DIV=1: tick every clock, one bit per cycle, no special casing.
//  No arithmetic overflow: bit_cnt is $clog2(WIDTH) bits and never exceeds WIDTH-1;
//   div_cnt never exceeds DIV-1.
// TESTING (bench with WIDTH=8, DIV=4)
//  1 Hold rst_n=0 for 2 clks with load=1 -> s_out=0, busy=0, done=0, pending=8'h00 throughout.
//  2 lr=1, 1-cycle load pulse, d_in=8'h0F -> s_out = 1,1,1,1,0,0,0,0, each bit 4 clks;
//    done pulses in cycle 33 after the accept edge; pending goes 0F,07,03,01,00,...
//  3 lr=0, d_in=8'h0F -> s_out = 0,0,0,0,1,1,1,1, each bit 4 clks; done after 32 bit clks.
//  4 Mid-frame (bit 2): pulse load with d_in=8'hFF and toggle lr -> stream and order unchanged,
//    busy stays 1.
//  5 rst_n=0 for 1 clk during bit 3 -> next cycle: busy=0, s_out=0, no done pulse;
//    a new load of 8'hA5 with lr=1 -> 1,0,1,0,0,1,0,1.
//  6 Hold load=1 continuously with d_in=8'h01 and lr=1 -> frames repeat; the next s_valid rise occurs
//    2 cycles after each done pulse; done pulse count equals frame count.

Source files
------------

// File: rtl/led_piso_tx.sv
// Parallel-in/serial-out LED shift transmitter with a built-in bit-rate prescaler.
// A word is loaded in IDLE and shifted out one bit every DIV clocks, LSB- or MSB-first.
module led_piso_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lr,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  output logic             s_out,
  output logic             s_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] pending
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic [BW-1:0]    bit_cnt, bit_cnt_next;
  logic [CW-1:0]    div_cnt, div_cnt_next;
  logic             dir, dir_next;
  logic             tick;

  assign tick    = (div_cnt == CW'(DIV - 1));
  assign pending = shreg;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the reset clears the whole datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      dir     <= 1'b0;
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      bit_cnt <= bit_cnt_next;
      div_cnt <= div_cnt_next;
      dir     <= dir_next;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    bit_cnt_next = bit_cnt;
    div_cnt_next = div_cnt;
    dir_next     = dir;
    s_out        = 1'b0;
    s_valid      = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;

    case (state)
      IDLE: begin
        if (load) begin
          shreg_next   = d_in;
          dir_next     = lr;
          bit_cnt_next = '0;
          div_cnt_next = '0;
          state_next   = SHIFT;
        end
      end

      SHIFT: begin
        s_out   = dir ? shreg[0] : shreg[WIDTH-1];
        s_valid = 1'b1;
        busy    = 1'b1;
        if (tick) begin
          div_cnt_next = '0;
          // The last bit leaves shreg untouched so pending still shows it in DONE.
          if (bit_cnt == BW'(WIDTH - 1)) begin
            state_next = DONE;
          end else begin
            bit_cnt_next = bit_cnt + 1'b1;
            shreg_next   = dir ? {1'b0, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], 1'b0};
          end
        end else begin
          div_cnt_next = div_cnt + 1'b1;
        end
      end

      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_led_piso_tx.sv
// Scoreboard bench for led_piso_tx (WIDTH=8, DIV=4): stimulus pushes expected per-cycle
// serial bits and done markers, a negedge monitor pops and compares them.
module tb_led_piso_tx;
  localparam int WIDTH = 8;
  localparam int DIV   = 4;

  logic             clk = 1'b0;
  logic             rst_n, lr, load;
  logic [WIDTH-1:0] d_in;
  logic             s_out, s_valid, busy, done;
  logic [WIDTH-1:0] pending;

  led_piso_tx #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .lr(lr), .load(load), .d_in(d_in),
    .s_out(s_out), .s_valid(s_valid), .busy(busy), .done(done), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_done;
    logic       s;
    logic [7:0] p;
  } item_t;

  item_t      sb[$];
  int         total = 0;
  int         bad   = 0;
  int         cyc = 0, done_cyc = 0, last_gap = 0, done_cnt = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] pend_tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected frame from the hand-computed pending table: DIV cycles per bit, then done.
  task automatic push_frame(input logic l);
    item_t it;
    for (int k = 0; k < WIDTH; k++) begin
      for (int d = 0; d < DIV; d++) begin
        it.is_done = 1'b0;
        it.s       = l ? pend_tbl[k][0] : pend_tbl[k][WIDTH-1];
        it.p       = pend_tbl[k];
        sb.push_back(it);
      end
    end
    it.is_done = 1'b1;
    it.s       = 1'b0;
    it.p       = pend_tbl[WIDTH-1];
    sb.push_back(it);
  endtask

  task automatic set_tbl(input logic [63:0] v);
    for (int k = 0; k < 8; k++) pend_tbl[k] = v[63-8*k -: 8];
  endtask

  task automatic accept(input logic [7:0] d, input logic l);
    @(posedge clk); #1;
    d_in = d; lr = l; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) return;
    end
    check({name, "_timeout"}, 0, 1);
  endtask

  always @(negedge clk) begin
    item_t it;
    cyc++;
    if (s_valid === 1'b1 && !prev_valid) last_gap = cyc - done_cyc;
    if (s_valid === 1'b1) begin
      if (sb.size() == 0) check("unexpected_bit", 1, 0);
      else begin
        it = sb.pop_front();
        check("kind_bit", it.is_done, 0);
        check("s_out", s_out, it.s);
        check("pending", pending, it.p);
        check("busy_shift", busy, 1);
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      check("done_after_last_bit", prev_valid, 1);
      check("done_outputs", {busy, s_valid, s_out}, 0);
      if (sb.size() == 0) check("unexpected_done", 1, 0);
      else begin
        it = sb.pop_front();
        check("kind_done", it.is_done, 1);
        check("pending_done", pending, it.p);
      end
    end
    prev_valid = (s_valid === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; load = 1'b1; lr = 1'b1; d_in = 8'hFF;

    // Reset held with load asserted.
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_outputs", {s_out, busy, done, s_valid}, 0);
      check("rst_pending", pending, 8'h00);
    end
    rst_n = 1'b1; load = 1'b0;
    @(posedge clk); #1;
    check("idle_outputs", {s_out, busy, done, s_valid}, 0);

    // LSB first, 0F.
    set_tbl(64'h0F07030100000000);
    push_frame(1'b1);
    accept(8'h0F, 1'b1);
    wait_done("lsb", n);
    check("lsb_done_cycle", n, 33);

    // MSB first, 0F.
    set_tbl(64'h0F1E3C78F0E0C080);
    push_frame(1'b0);
    accept(8'h0F, 1'b0);
    wait_done("msb", n);
    check("msb_done_cycle", n, 33);

    // Load pulse and lr toggle during bit 2 are ignored.
    set_tbl(64'h0F07030100000000);
    push_frame(1'b1);
    accept(8'h0F, 1'b1);
    repeat (9) @(posedge clk);
    #1; d_in = 8'hFF; lr = 1'b0; load = 1'b1;
    @(negedge clk);
    check("busy_midframe", busy, 1);
    @(posedge clk); #1; load = 1'b0;
    wait_done("ignore", n);
    check("ignore_done_cycle", n, 23);

    // Reset during bit 3 aborts the frame without done.
    set_tbl(64'h0F1E3C78F0E0C080);
    push_frame(1'b0);
    accept(8'h0F, 1'b0);
    repeat (13) @(posedge clk);
    #1; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    check("abort_outputs", {busy, s_out, done, s_valid}, 0);
    check("abort_pending", pending, 8'h00);
    repeat (4) @(posedge clk);
    set_tbl(64'hA55229140A050201);
    push_frame(1'b1);
    accept(8'hA5, 1'b1);
    wait_done("a5", n);
    check("a5_done_cycle", n, 33);

    // Load held high: back-to-back frames two cycles apart.
    set_tbl(64'h0100000000000000);
    @(posedge clk); #1;
    d_in = 8'h01; lr = 1'b1; load = 1'b1;
    for (int f = 0; f < 3; f++) begin
      push_frame(1'b1);
      wait_done("hold", n);
      if (f == 2) load = 1'b0;
      if (f > 0) check("hold_gap", last_gap, 2);
    end
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("hold_idle", {busy, s_valid, done}, 0);
    check("done_count", done_cnt, 7);
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
